// File: rtl/mux_scan.sv
// Registered N-channel, W-bit mux with direct select and auto-scan modes; tags output with channel, valid, wrap.
// Latency: 1 cycle from sampling edge to dout/ch/valid/wrap.
// No backpressure: en=0 freezes data, pointer and dwell count and drops valid/wrap.
module mux_scan #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    din,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   ch,
    output logic              valid,
    output logic              wrap
);

    localparam int               CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW:0]    N_EXT  = (SELW+1)'(N);
    localparam logic [SELW-1:0]  P_LAST = SELW'(N - 1);
    localparam logic [CW-1:0]    C_LAST = CW'(DWELL - 1);

    // Channels unpacked into an array padded to the full select range,
    // so any select value indexes a defined entry (unused ones read zero).
    logic [W-1:0] chan [2**SELW];

    for (genvar k = 0; k < 2**SELW; k++) begin : g_chan
        if (k < N) begin : g_used
            assign chan[k] = din[k*W +: W];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    logic [SELW-1:0] p;
    logic [CW-1:0]   c;
    logic            mode_q;
    logic [SELW-1:0] p_eff;
    logic [CW-1:0]   c_eff;

    // Entering scan from direct mode restarts the sweep at channel 0 with a fresh dwell.
    always_comb begin
        p_eff = mode_q ? p : '0;
        c_eff = mode_q ? c : '0;
    end

    // Output registers plus scan pointer/dwell counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            ch     <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            p      <= '0;
            c      <= '0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode;
            if (!en) begin
                valid <= 1'b0;
                wrap  <= 1'b0;
            end else if (!mode) begin
                wrap <= 1'b0;
                p    <= '0;
                c    <= '0;
                if ({1'b0, sel} < N_EXT) begin
                    dout  <= chan[sel];
                    ch    <= sel;
                    valid <= 1'b1;
                end else begin
                    dout  <= '0;
                    valid <= 1'b0;
                end
            end else begin
                dout  <= chan[p_eff];
                ch    <= p_eff;
                valid <= 1'b1;
                if (c_eff == C_LAST) begin
                    c    <= '0;
                    wrap <= (p_eff == P_LAST);
                    p    <= (p_eff == P_LAST) ? '0 : p_eff + SELW'(1);
                end else begin
                    c    <= c_eff + CW'(1);
                    wrap <= 1'b0;
                    p    <= p_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: directed steps plus a random tail against a sample-count model.
// Latency: outputs compared 1 time unit after each rising edge.
// No backpressure in the design; en gaps are exercised explicitly.
module tb_mux_scan;

    localparam int N     = 3;
    localparam int W     = 1;
    localparam int SELW  = 2;
    localparam int DWELL = 2;
    localparam int SWEEP = N * DWELL;

    logic              clk = 1'b0;
    logic              rst, en, mode;
    logic [SELW-1:0]   sel;
    logic [N*W-1:0]    din;
    logic [W-1:0]      dout;
    logic [SELW-1:0]   ch;
    logic              valid, wrap;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: scan position is just "samples taken since the sweep restarted".
    logic [W-1:0]    m_dout;
    logic [SELW-1:0] m_ch;
    logic            m_valid, m_wrap;
    logic            m_mode_prev;
    int              k;

    always #5 clk = ~clk;

    mux_scan #(.N(N), .W(W), .SELW(SELW), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .din   (din),
        .dout  (dout),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap)
    );

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input int idx);
        return W'(d >> (idx * W));
    endfunction

    task automatic model_edge();
        int idx;
        if (rst) begin
            m_dout = '0; m_ch = '0; m_valid = 1'b0; m_wrap = 1'b0;
            k = 0; m_mode_prev = 1'b0;
        end else begin
            if (!en) begin
                m_valid = 1'b0;
                m_wrap  = 1'b0;
            end else if (!mode) begin
                k      = 0;
                m_wrap = 1'b0;
                if (int'(sel) < N) begin
                    m_dout  = pick(din, int'(sel));
                    m_ch    = sel;
                    m_valid = 1'b1;
                end else begin
                    m_dout  = '0;
                    m_valid = 1'b0;
                end
            end else begin
                if (!m_mode_prev) k = 0;
                idx     = (k / DWELL) % N;
                m_dout  = pick(din, idx);
                m_ch    = SELW'(idx);
                m_valid = 1'b1;
                m_wrap  = ((k % SWEEP) == SWEEP - 1);
                k       = (k + 1) % SWEEP;
            end
            m_mode_prev = mode;
        end
    endtask

    task automatic check();
        vectors++;
        assert (dout === m_dout) else begin
            miscompares++;
            $error("FAIL dout: got %0h expected %0h at %0t", dout, m_dout, $time);
        end
        vectors++;
        assert (ch === m_ch) else begin
            miscompares++;
            $error("FAIL ch: got %0d expected %0d at %0t", ch, m_ch, $time);
        end
        vectors++;
        assert (valid === m_valid) else begin
            miscompares++;
            $error("FAIL valid: got %0b expected %0b at %0t", valid, m_valid, $time);
        end
        vectors++;
        assert (wrap === m_wrap) else begin
            miscompares++;
            $error("FAIL wrap: got %0b expected %0b at %0t", wrap, m_wrap, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic md,
                        input logic [SELW-1:0] s, input logic [N*W-1:0] d);
        rst = r; en = e; mode = md; sel = s; din = d;
        @(posedge clk);
        model_edge();
        #1;
        check();
    endtask

    function automatic logic [N*W-1:0] rnd_din();
        return (N*W)'($urandom);
    endfunction

    initial begin
        logic r_mode;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; din = '0;

        // Reset held for two cycles with random data on the bus
        step(1, 0, 0, 0, rnd_din());
        step(1, 1, 1, 2, rnd_din());
        // Released but disabled: outputs stay at reset values
        step(0, 0, 0, 1, rnd_din());
        step(0, 0, 0, 2, rnd_din());

        // Direct select over 3'b101, then an out-of-range select
        step(0, 1, 0, 0, 3'b101);
        step(0, 1, 0, 1, 3'b101);
        step(0, 1, 0, 2, 3'b101);
        step(0, 1, 0, 3, 3'b101);

        // Continuous scan from idle: two full sweeps plus a bit
        for (int i = 0; i < 14; i++) step(0, 1, 1, 0, rnd_din());

        // Restart, stop mid-dwell on channel 1, gap of 3 disabled cycles, resume
        step(0, 1, 0, 0, rnd_din());
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, rnd_din());
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, rnd_din());
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, rnd_din());

        // Sample on channel 2, drop to direct sel=1, then return to scan
        step(0, 1, 1, 0, rnd_din());
        step(0, 1, 0, 1, rnd_din());
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, rnd_din());

        // Reset mid-dwell, then the scan restarts from channel 0
        step(1, 1, 1, 0, rnd_din());
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, rnd_din());

        // Random tail: sticky mode, frequent en gaps, rare resets
        r_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) r_mode = ~r_mode;
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 r_mode,
                 SELW'($urandom),
                 rnd_din());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. It is the successor of the 3-input single-bit lab mux.
- Adds two modes:
  - direct mode: an external select chooses the channel.
  - auto-scan mode: an internal sequencer cycles through all channels, holding each one for a programmable dwell time.
- Sits between a packed bank of sources and a single consumer. Output data is tagged with channel index, valid and wrap strobes.

Parameters:
- N, 3, number of input channels (N >= 2).
- W, 1, bit width of each channel.
- SELW, 2, width of select/channel index; must satisfy 2**SELW >= N.
- DWELL, 4, cycles spent on each channel in scan mode (DWELL >= 1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance/sample enable.
- mode  input  1  0 = direct select, 1 = auto-scan.
- sel  input  SELW  channel select, used in direct mode only.
- din  input  N*W  packed channels; channel k = din[k*W +: W].
- dout  output  W  registered selected data.
- ch  output  SELW  channel index that dout came from.
- valid  output  1  dout/ch hold a fresh sample this cycle.
- wrap  output  1  one-cycle strobe on the last sample of a full scan.

Behaviour:
Reset (synchronous, rst=1 at a rising edge):
- dout=0, ch=0, valid=0, wrap=0.
- Internal scan pointer p=0, dwell counter c=0, mode_q=0.
- rst has priority over all other inputs, including mid-scan.

General rules:
- All outputs are registered. Latency is 1 cycle: the sample chosen at edge k appears on dout after edge k and is stable through cycle k+1.
- en=0: dout, ch, p and c hold their values; valid=0, wrap=0. mode_q still tracks mode.

Direct mode (mode=1'b0, en=1):
- If sel < N: dout<=din[sel], ch<=sel, valid<=1.
- If sel >= N: dout<=0, ch holds, valid<=0.
- wrap=0, c<=0, p<=0.

Scan mode (mode=1'b1, en=1):
- Each enabled cycle: dout<=din[p], ch<=p, valid<=1.
- If c==DWELL-1:
  - c<=0.
  - p<=p+1, or p<=0 when p==N-1.
  - wrap<=1 if p==N-1, else wrap<=0.
- Otherwise: c<=c+1, wrap<=0.
- DWELL=1: p advances every enabled cycle.

Mode entry and exit:
- Direct-to-scan (mode=1 while mode_q=0): the scan restarts. The sample this cycle uses p=0, with c treated as 0. From this cycle on, the scan-mode rules apply: c becomes 1 (or 0 with p advancing if DWELL=1).
- Scan-to-direct: takes effect the same edge. The scan state is discarded and p, c are cleared.

Other rules:
- Sampling is combinational on din at the edge; no din registering beyond dout.
- The counter c is wide enough for DWELL-1.
- The index p never exceeds N-1.

Test Plan:
- Reset: rst=1 for 2 cycles with random din -> dout=0, ch=0, valid=0, wrap=0. Release rst, en=0 -> outputs unchanged.
- Direct select (N=3, W=1, din=3'b101): sel=0,1,2 on consecutive cycles with en=1 -> after each edge dout=1,0,1; ch=0,1,2; valid=1, one-cycle latency.
- Invalid select: sel=3, N=3, en=1 -> dout=0, valid=0, ch retains 2, wrap=0.
- Scan sequence (N=3, DWELL=2, en=1 constant, mode=1 from idle) -> ch over successive cycles = 0,0,1,1,2,2,0,0. wrap=1 only on the 6th sample (second ch=2), then every 6 cycles. dout tracks din of the shown channel.
- Enable gap: during scan, deassert en for 3 cycles mid-dwell on ch=1 -> valid=0 and ch/dout frozen during the gap. On resume, the remaining dwell on ch=1 completes and the sequence continues without skip.
- Mode switch and reset mid-scan:
  - At ch=2, switch mode to 0 with sel=1 -> next ch=1.
  - Return mode to 1 -> scan restarts at ch=0.
  - Assert rst mid-dwell -> all outputs 0 the next cycle; scan restarts at ch=0 after release.
